gf2_lin_solver: RTL and testbench
=================================

Name: gf2_lin_solver

Overview:
- Inverse direction of the binary matrix-vector multiplier. That block computes y = A·x over GF(2), with AND as multiply and XOR as add.
- This block takes A and y and recovers x using sequential Gauss-Jordan elimination.
- It sits behind the multiplier in the binary_matrix datapath as its decoding counterpart.
- Valid/ready handshake on both input and output sides; one solve in flight at a time.

Parameters:
- N, 4, matrix dimension (N×N) and vector width; legal range 2..8.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  mat/y present a problem.
- in_ready  output  1  block idle and able to accept.
- mat  input  N*N  row-major A; bit i*N+j = A[i][j].
- y  input  N  right-hand side; bit i = y[i].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- x  output  N  solution; bit j = x[j].
- singular  output  1  A not invertible over GF(2); x forced to 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE, in_ready = 1, out_valid = 0, x = 0, singular = 0.
  - Internal augmented matrix and column counter are cleared.
  - Reset mid-solve abandons the solve immediately; no partial result is ever presented.
- States: IDLE, PIVOT, ELIM, DONE. in_ready = (state == IDLE), registered.
- IDLE: on the edge where in_valid & in_ready, capture the augmented rows {y[i], A[i][*]}, set col = 0, go to PIVOT.
- PIVOT (1 cycle):
  - Find the lowest row index r ≥ col with A[r][col] = 1.
  - Found: swap rows r and col (no-op when r == col), go to ELIM.
  - None: singular = 1, x = 0, go to DONE.
- ELIM (1 cycle):
  - Every row i ≠ col with A[i][col] = 1 is XORed with row col, including the y bit.
  - Then, if col == N-1: x[j] = augmented y bit of row j, singular = 0, go to DONE. Otherwise col++ and go to PIVOT.
- DONE:
  - out_valid = 1; x and singular are held stable until out_ready.
  - On the edge where out_valid & out_ready: go to IDLE, out_valid = 0. in_ready rises the cycle after.
  - No bypass: in_valid in the same cycle is ignored.
- Latency, counted in edges after the accepting edge:
  - Nonsingular: out_valid asserted after exactly 2N edges.
  - Singular detected at column c: out_valid asserted after 2c+1 edges.
- in_valid while busy: ignored; mat/y are not sampled.
- All arithmetic is bitwise GF(2); no carries, no width growth.

Decomposition:
- Package gf2_pkg holds:
  - state encoding localparams (IDLE=0, PIVOT=1, ELIM=2, DONE=3);
  - default N;
  - bit-index helper function idx(i, j) = i*N + j.
- One natural sub-module: gf2_pivot_find. It is a combinational priority encoder over column col for rows ≥ col, with outputs found and row index.
- The row-swap/XOR datapath stays in the top module.

Test Plan:
- N=2, mat=4'b1001 (identity), y=2'b10 → x=2'b10, singular=0, out_valid exactly 4 edges after accept.
- N=2, mat=4'b0110 (swap matrix), y=2'b01 → x=2'b10, singular=0. Row swap is exercised at col 0.
- N=2, mat=4'b1111, y=2'b01 → singular=1, x=2'b00, out_valid 3 edges after accept.
- N=4, mat=16'h8CEF (upper triangular, all ones), y=4'b1101 → x=4'b1011, out_valid 8 edges after accept. Re-multiplying with the 2x2/4x4 multiplier model must reproduce y.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new data → x/singular stable, in_ready=0 throughout, the second problem is not captured. Then out_ready=1 → IDLE, and the next problem is solved correctly.
- Reset mid-operation: drop rst_n during ELIM of col 1 (N=4) → out_valid=0 and in_ready=1 asynchronously. After release, a fresh solve with mat=16'h8421 (identity), y=4'b0110 gives x=4'b0110.

Source files
------------

// File: rtl/gf2_lin_solver_pkg.sv
// gf2_pkg: shared definitions for the GF(2) linear solver.
//   state_t : controller state encoding (IDLE=0, PIVOT=1, ELIM=2, DONE=3)
//   N_DEF   : default matrix dimension
//   idx     : flat bit index of A[i][j] in a row-major N*N vector
package gf2_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PIVOT = 2'd1,
      ELIM  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int idx(input int i, input int j, input int n);
      return i * n + j;
   endfunction

endpackage

// File: rtl/gf2_lin_solver_pivot_find.sv
// gf2_pivot_find: combinational priority encoder that picks the pivot row
// for the current elimination column.
//   col_bits : bit r = A[r][col] of the working matrix
//   col      : current column (only rows >= col are candidates)
//   found    : a candidate row with a 1 in this column exists
//   row      : lowest such row index (0 when not found)
module gf2_pivot_find #(
   parameter int N  = 4,
   parameter int CW = 2
) (
   input  logic [N-1:0]  col_bits,
   input  logic [CW-1:0] col,
   output logic          found,
   output logic [CW-1:0] row
);

   always_comb begin
      found = 1'b0;
      row   = '0;
      for (int r = 0; r < N; r++) begin
         if (!found && (r >= int'(col)) && col_bits[r]) begin
            found = 1'b1;
            row   = CW'(r);
         end
      end
   end

endmodule

// File: rtl/gf2_lin_solver.sv
// gf2_lin_solver: solves A*x = y over GF(2) by sequential Gauss-Jordan
// elimination, one PIVOT and one ELIM cycle per column.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : problem handshake (mat = row-major A, y = RHS)
//   out_valid/out_ready : result handshake (x, singular)
//   state               : controller state, exported for observation
// Handshake: a transfer happens on the rising edge where valid and ready are
// both high; a producer holds valid and its data stable until that edge, and
// ready never depends combinationally on valid. One solve is in flight at a
// time: in_ready is high only in IDLE, out_valid only in DONE.
module gf2_lin_solver
   import gf2_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N*N-1:0] mat,
   input  logic [N-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] x,
   output logic         singular,
   output state_t       state
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Augmented matrix kept as A rows plus a separate RHS bit per row.
   logic [N-1:0]  a_row  [N];
   logic [N-1:0]  yv;
   logic [N-1:0]  a_elim [N];
   logic [N-1:0]  y_elim;
   logic [CW-1:0] col;
   logic [N-1:0]  col_bits;
   logic          piv_found;
   logic [CW-1:0] piv_row;
   logic          last_col;
   state_t        state_next;

   assign last_col = (col == CW'(N - 1));

   always_comb begin
      col_bits = '0;
      for (int r = 0; r < N; r++) begin
         col_bits[r] = a_row[r][col];
      end
   end

   gf2_pivot_find #(.N(N), .CW(CW)) u_pivot (
      .col_bits(col_bits),
      .col     (col),
      .found   (piv_found),
      .row     (piv_row)
   );

   // Clear column col from every other row; the pivot row itself is kept.
   always_comb begin
      y_elim = yv;
      for (int i = 0; i < N; i++) begin
         a_elim[i] = a_row[i];
         if ((i != int'(col)) && a_row[i][col]) begin
            a_elim[i] = a_row[i] ^ a_row[col];
            y_elim[i] = yv[i] ^ yv[col];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = PIVOT;
         end
         PIVOT:   state_next = piv_found ? ELIM : DONE;
         ELIM:    state_next = last_col ? DONE : PIVOT;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) a_row[i] <= '0;
         yv       <= '0;
         col      <= '0;
         x        <= '0;
         singular <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < N; i++) a_row[i] <= mat[idx(i, 0, N) +: N];
                  yv  <= y;
                  col <= '0;
               end
            end
            PIVOT: begin
               if (piv_found) begin
                  // When piv_row == col both writes carry the same value.
                  a_row[col]     <= a_row[piv_row];
                  a_row[piv_row] <= a_row[col];
                  yv[col]        <= yv[piv_row];
                  yv[piv_row]    <= yv[col];
               end else begin
                  singular <= 1'b1;
                  x        <= '0;
               end
            end
            ELIM: begin
               for (int i = 0; i < N; i++) a_row[i] <= a_elim[i];
               yv <= y_elim;
               if (last_col) begin
                  // A is now the identity, so the RHS column is x.
                  x        <= y_elim;
                  singular <= 1'b0;
               end else begin
                  col <= col + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_lin_solver.sv
// Bench for gf2_lin_solver: one N=2 and one N=4 instance, directed problems
// with hand-solved answers, a per-instance expected queue and monitor.
module tb_gf2_lin_solver;
   import gf2_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   // N=2 instance
   logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
   logic       in_ready2, out_valid2, singular2;
   logic [3:0] mat2 = '0;
   logic [1:0] y2 = '0;
   logic [1:0] x2;
   state_t     state2;

   // N=4 instance
   logic        in_valid4 = 1'b0, out_ready4 = 1'b1;
   logic        in_ready4, out_valid4, singular4;
   logic [15:0] mat4 = '0;
   logic [3:0]  y4 = '0;
   logic [3:0]  x4;
   state_t      state4;

   gf2_lin_solver #(.N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .mat(mat2), .y(y2), .out_valid(out_valid2), .out_ready(out_ready2),
      .x(x2), .singular(singular2), .state(state2)
   );

   gf2_lin_solver #(.N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .mat(mat4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready4),
      .x(x4), .singular(singular4), .state(state4)
   );

   // Expected entries: {mat, y, singular, x}; expected out_valid rise cycle.
   logic [8:0]  exp2_q[$];
   int          rise2_q[$];
   logic [24:0] exp4_q[$];
   int          rise4_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [1:0] mul2(input logic [3:0] m, input logic [1:0] v);
      logic [1:0] r;
      for (int i = 0; i < 2; i++) r[i] = ^(m[i*2 +: 2] & v);
      return r;
   endfunction

   function automatic logic [3:0] mul4(input logic [15:0] m, input logic [3:0] v);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ^(m[i*4 +: 4] & v);
      return r;
   endfunction

   // Monitor, N=2
   logic prev2 = 1'b0;
   int   rise2 = 0;
   always @(negedge clk) begin
      logic [8:0] e;
      int r;
      #1;
      if (!rst_n) prev2 = 1'b0;
      else begin
         if (out_valid2 && !prev2) rise2 = cyc;
         prev2 = out_valid2;
         if (out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL dut2_unexpected_output: got x=%0b singular=%0b with nothing outstanding", x2, singular2);
            end else begin
               e = exp2_q.pop_front();
               r = rise2_q.pop_front();
               check("dut2_x", x2, e[1:0]);
               check("dut2_singular", singular2, e[2]);
               check("dut2_latency_cycle", rise2, r);
               if (!e[2]) check("dut2_remultiply", mul2(e[8:5], x2), e[4:3]);
            end
         end
      end
   end

   // Monitor, N=4
   logic prev4 = 1'b0;
   int   rise4 = 0;
   always @(negedge clk) begin
      logic [24:0] e;
      int r;
      #1;
      if (!rst_n) prev4 = 1'b0;
      else begin
         if (out_valid4 && !prev4) rise4 = cyc;
         prev4 = out_valid4;
         if (out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL dut4_unexpected_output: got x=%0b singular=%0b with nothing outstanding", x4, singular4);
            end else begin
               e = exp4_q.pop_front();
               r = rise4_q.pop_front();
               check("dut4_x", x4, e[3:0]);
               check("dut4_singular", singular4, e[4]);
               check("dut4_latency_cycle", rise4, r);
               if (!e[4]) check("dut4_remultiply", mul4(e[24:9], x4), e[8:5]);
            end
         end
      end
   end

   task automatic issue2(input logic [3:0] m, input logic [1:0] yy, input logic s,
                         input logic [1:0] ex, input int lat);
      int n;
      @(negedge clk);
      in_valid2 = 1'b1;
      mat2 = m;
      y2 = yy;
      n = 0;
      while (!in_ready2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready2) begin
         checks++;
         failures++;
         $display("FAIL dut2_accept_timeout: in_ready=%0b, required 1", in_ready2);
         in_valid2 = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      exp2_q.push_back({m, yy, s, ex});
      rise2_q.push_back(cyc + lat);
      @(negedge clk);
      in_valid2 = 1'b0;
   endtask

   task automatic issue4(input logic [15:0] m, input logic [3:0] yy, input logic s,
                         input logic [3:0] ex, input int lat, input bit track);
      int n;
      @(negedge clk);
      in_valid4 = 1'b1;
      mat4 = m;
      y4 = yy;
      n = 0;
      while (!in_ready4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready4) begin
         checks++;
         failures++;
         $display("FAIL dut4_accept_timeout: in_ready=%0b, required 1", in_ready4);
         in_valid4 = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (track) begin
         exp4_q.push_back({m, yy, s, ex});
         rise4_q.push_back(cyc + lat);
      end
      @(negedge clk);
      in_valid4 = 1'b0;
   endtask

   task automatic wait_done2();
      int n;
      n = 0;
      while ((exp2_q.size() != 0 || !in_ready2) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp2_q.size() != 0 || !in_ready2) begin
         checks++;
         failures++;
         $display("FAIL dut2_done_timeout: outstanding=%0d, required 0", exp2_q.size());
         exp2_q.delete();
         rise2_q.delete();
      end
   endtask

   task automatic wait_done4();
      int n;
      n = 0;
      while ((exp4_q.size() != 0 || !in_ready4) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp4_q.size() != 0 || !in_ready4) begin
         checks++;
         failures++;
         $display("FAIL dut4_done_timeout: outstanding=%0d, required 0", exp4_q.size());
         exp4_q.delete();
         rise4_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready2", in_ready2, 1'b1);
      check("rst_out_valid2", out_valid2, 1'b0);
      check("rst_x2", x2, 2'b00);
      check("rst_singular2", singular2, 1'b0);
      check("rst_state2", state2, IDLE);
      check("rst_in_ready4", in_ready4, 1'b1);
      check("rst_out_valid4", out_valid4, 1'b0);
      check("rst_x4", x4, 4'b0000);
      rst_n = 1'b1;

      // 2x2 problems
      issue2(4'b1001, 2'b10, 1'b0, 2'b10, 4);  // identity
      wait_done2();
      issue2(4'b0110, 2'b01, 1'b0, 2'b10, 4);  // row swap at col 0
      wait_done2();
      issue2(4'b1111, 2'b01, 1'b1, 2'b00, 3);  // singular at col 1
      wait_done2();

      // 4x4 problems
      issue4(16'h8CEF, 4'b1101, 1'b0, 4'b1011, 8, 1'b1);  // upper triangular
      wait_done4();
      issue4(16'hF731, 4'b1011, 1'b0, 4'b1101, 8, 1'b1);  // lower triangular
      wait_done4();
      issue4(16'h4421, 4'b1111, 1'b1, 4'b0000, 7, 1'b1);  // singular at last col
      wait_done4();
      issue4(16'h0000, 4'b0101, 1'b1, 4'b0000, 1, 1'b1);  // singular at col 0
      wait_done4();

      // Backpressure: hold result while new problems are offered
      out_ready4 = 1'b0;
      issue4(16'h1248, 4'b0011, 1'b0, 4'b1100, 8, 1'b1);  // anti-diagonal
      n = 0;
      while (!out_valid4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_out_valid_seen", out_valid4, 1'b1);
      for (int k = 0; k < 5; k++) begin
         in_valid4 = (k % 2 == 0);
         mat4 = 16'h8421;
         y4 = 4'(k + 1);
         @(negedge clk);
         check("bp_in_ready_low", in_ready4, 1'b0);
         check("bp_out_valid_held", out_valid4, 1'b1);
         check("bp_x_stable", x4, 4'b1100);
         check("bp_singular_stable", singular4, 1'b0);
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b1;
      @(negedge clk);
      check("bp_in_ready_after", in_ready4, 1'b1);
      check("bp_out_valid_after", out_valid4, 1'b0);
      issue4(16'h8421, 4'b1010, 1'b0, 4'b1010, 8, 1'b1);
      wait_done4();

      // Reset during ELIM of column 1: the solve is abandoned
      issue4(16'hF731, 4'b0110, 1'b0, 4'b0000, 8, 1'b0);
      repeat (3) @(negedge clk);
      check("mid_state_elim", state4, ELIM);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid4, 1'b0);
      check("mid_rst_in_ready", in_ready4, 1'b1);
      check("mid_rst_state", state4, IDLE);
      check("mid_rst_x", x4, 4'b0000);
      check("mid_rst_singular", singular4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue4(16'h8421, 4'b0110, 1'b0, 4'b0110, 8, 1'b1);
      wait_done4();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
